// File: rtl/coef_bank_ctrl.sv
// rtl/coef_bank_ctrl.sv - coefficient tap sweeper with shadow/active double-buffered bank
// Optional feature macro: COEF_BANK_READBACK_EN (registered shadow-bank read port).
module coef_bank_ctrl #(
  parameter int COEFW = 18,
  parameter int TM    = 2,
  parameter int CW    = 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             sample_valid,
  output logic             sweep_active,
  output logic [CW-1:0]    counter_out,
  output logic             phase_last,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CW-1:0]    wr_addr,
  input  logic [COEFW-1:0] wr_data,
  input  logic             commit,
  output logic             commit_done,
  output logic [COEFW-1:0] coef_pack [TM],
  output logic [1:0]       err,
  input  logic             err_clr
`ifdef COEF_BANK_READBACK_EN
  ,
  input  logic [CW-1:0]    rd_addr,
  output logic [COEFW-1:0] rd_data
`endif
);

  localparam logic [CW-1:0] LAST = CW'(TM - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt_d;
  logic             sweep_d;
  logic             last_d;

  logic             pending;
  logic             pending_d;
  logic             copy_now;
  logic             wr_fire;
  logic             addr_ok;
  logic             ovr_evt;
  logic             bad_evt;
  logic [COEFW-1:0] shadow [TM];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      counter_out  <= '0;
      sweep_active <= 1'b0;
      phase_last   <= 1'b0;
    end else begin
      state        <= state_d;
      counter_out  <= cnt_d;
      sweep_active <= sweep_d;
      phase_last   <= last_d;
    end
  end

  // A new request is only honoured from IDLE or on the final tap.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (sample_valid) state_d = SWEEP;
      SWEEP:   if (phase_last && !sample_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = '0;
    sweep_d = 1'b0;
    last_d  = 1'b0;
    if (state_d == SWEEP) begin
      sweep_d = 1'b1;
      if (state == SWEEP && !phase_last) cnt_d = counter_out + 1'b1;
      last_d = (cnt_d == LAST);
    end
  end

  assign ovr_evt   = (state == SWEEP) && !phase_last && sample_valid;
  assign wr_fire   = wr_valid && wr_ready;
  assign addr_ok   = int'(wr_addr) < TM;
  assign bad_evt   = wr_fire && !addr_ok;
  // Bank swap waits for a sweep boundary so a sweep never mixes old and new taps.
  assign copy_now  = pending && ((state == IDLE) || phase_last);
  assign pending_d = pending ? !copy_now : commit;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pending     <= 1'b0;
      wr_ready    <= 1'b0;
      commit_done <= 1'b0;
      err         <= 2'b00;
      for (int i = 0; i < TM; i++) begin
        shadow[i]    <= '0;
        coef_pack[i] <= '0;
      end
    end else begin
      pending     <= pending_d;
      wr_ready    <= !pending_d;
      commit_done <= copy_now;
      if (err_clr) err <= 2'b00;
      else         err <= err | {bad_evt, ovr_evt};
      for (int i = 0; i < TM; i++) begin
        if (wr_fire && addr_ok && int'(wr_addr) == i) shadow[i] <= wr_data;
        if (copy_now) coef_pack[i] <= shadow[i];
      end
    end
  end

`ifdef COEF_BANK_READBACK_EN
  logic [COEFW-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < TM; i++) begin
      if (int'(rd_addr) == i) rd_mux = shadow[i];
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rd_data <= '0;
    else          rd_data <= rd_mux;
  end
`endif

endmodule
